qed_consistency_checker: RTL
============================

# qed_consistency_checker

Back end of the QED flow: it checks that original and duplicate instructions produced identical architectural state. It counts committed original and duplicate (upper-half/upper-partition) instructions. When the counts match, it scans register pairs r[i]/r[i+16] and data-memory word pairs m[i]/m[i+16] through dedicated read ports. It raises a sticky error on the first mismatch. It sits beside the core's register file and 32-deep data RAM and observes the commit stream.

## Interface
Parameters:
- XLEN, 32, register/memory word width
- CNT_W, 16, commit counter width (wraps)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- qed_ena  input  1  QED mode active; when low, counters hold and FSM forced to IDLE
- commit_valid  input  1  one instruction committed this cycle
- commit_is_dup  input  1  committed instruction is a duplicate (destination/partition in upper half)
- pipe_empty  input  1  no instruction in flight past fetch
- rf_addr_a / rf_addr_b  output  5 each  register read addresses (lower / upper)
- rf_data_a / rf_data_b  input  XLEN each  read data, valid 1 cycle after address
- mem_addr_a / mem_addr_b  output  5 each  word addresses (lower / upper partition)
- mem_data_a / mem_data_b  input  XLEN each  read data, valid 1 cycle after address
- check_done  output  1  one-cycle pulse when a full scan completes without abort
- qed_error  output  1  sticky mismatch flag
- err_index  output  4  index i of first mismatch
- err_is_mem  output  1  first mismatch was in memory (0 = register)

## Operation
- Counters: orig_cnt increments on commit_valid & !commit_is_dup; dup_cnt increments on commit_valid & commit_is_dup. Both are CNT_W bits, wrap modulo 2^CNT_W, reset to 0. last_chk (CNT_W) resets to 0.
- Trigger condition: qed_ena & pipe_empty & !commit_valid & orig_cnt==dup_cnt & orig_cnt!=last_chk.
- FSM states:
  - IDLE: on trigger, go to RF_SCAN with idx=1 and snap=orig_cnt.
  - RF_SCAN: each cycle drive rf_addr_a=idx and rf_addr_b=idx+16, then increment idx. After idx=15 is issued, go to MEM_SCAN with idx=0. Register 0 is never compared.
  - MEM_SCAN: drive mem_addr_a=idx and mem_addr_b=idx+16 for idx 0..15. After idx=15 is issued, go to DRAIN.
  - DRAIN: the last comparison completes; then go to IDLE, set last_chk=snap and pulse check_done.
- Compare stage: one registered "pending" bit plus the pending index and type. On the cycle after an address is issued, compare a vs b data. On inequality with qed_error=0, set qed_error, err_index and err_is_mem.
- Abort: commit_valid or !qed_ena in any non-IDLE state returns the FSM to IDLE next cycle.
  - No check_done pulse; last_chk is unchanged, so the scan retriggers later.
  - A compare already pending in that cycle is discarded.
- qed_error stays set until rst. Scans continue after an error, but err_* fields are not overwritten.
- Addresses are 0 while in IDLE.

## Timing
- Reset values: all addresses 0, check_done 0, qed_error 0, err_index 0, err_is_mem 0, FSM IDLE, counters 0.
- Trigger seen in cycle T:
  - First rf address is driven in T+1.
  - Memory addresses are driven in T+16..T+31.
  - DRAIN is in T+32; check_done pulses in T+33 (config on).
- qed_error rises 2 cycles after the mismatching address is issued.
- Commit and trigger in the same cycle: the trigger is blocked by the !commit_valid term.
- Counter wrap: equality is compared on wrapped values; no special handling.

## Configuration
- QED_MEM_CHECK_EN defined: the MEM_SCAN state exists as above.
- QED_MEM_CHECK_EN undefined:
  - RF_SCAN goes directly to DRAIN after idx=15; check_done pulses at T+17.
  - mem_addr_a/b are tied to 0 and err_is_mem is tied to 0.

## Test plan
- Reset, then 3 originals and 3 duplicates with identical data, pipe_empty=1 → check_done pulse at T+33, qed_error=0, last_chk=3.
- rf_data for r5=0x1234 vs r21=0x1235 → qed_error=1, err_index=5, err_is_mem=0. A later mismatch at r9 leaves err_index=5.
- Memory word 7=0xA5 vs word 23=0x5A → qed_error=1, err_index=7, err_is_mem=1.
- commit_valid pulsed during RF_SCAN idx=8 → FSM returns to IDLE and there is no check_done. After counts rebalance (4/4), the scan reruns from idx=1.
- orig_cnt=2, dup_cnt=1 while idle → no scan. After one more duplicate commit, the scan starts. With counts held equal after the scan, no second scan occurs.
- With QED_MEM_CHECK_EN undefined → check_done at T+17 and mem_addr_* stay 0 throughout.

Source files
------------

// File: rtl/qed_consistency_checker_if.sv
// Signal bundle between the QED consistency checker and its environment:
// commit stream, register-file and data-RAM read ports, and check status.
interface qed_consistency_checker_if #(
  parameter int unsigned XLEN = 32
);
  logic            qed_ena;
  logic            commit_valid;
  logic            commit_is_dup;
  logic            pipe_empty;
  logic [4:0]      rf_addr_a;
  logic [4:0]      rf_addr_b;
  logic [XLEN-1:0] rf_data_a;
  logic [XLEN-1:0] rf_data_b;
  logic [4:0]      mem_addr_a;
  logic [4:0]      mem_addr_b;
  logic [XLEN-1:0] mem_data_a;
  logic [XLEN-1:0] mem_data_b;
  logic            check_done;
  logic            qed_error;
  logic [3:0]      err_index;
  logic            err_is_mem;

  // Core side: drives the commit stream and returns read data.
  modport master (
    output qed_ena, commit_valid, commit_is_dup, pipe_empty,
    output rf_data_a, rf_data_b, mem_data_a, mem_data_b,
    input  rf_addr_a, rf_addr_b, mem_addr_a, mem_addr_b,
    input  check_done, qed_error, err_index, err_is_mem
  );

  // Checker side.
  modport slave (
    input  qed_ena, commit_valid, commit_is_dup, pipe_empty,
    input  rf_data_a, rf_data_b, mem_data_a, mem_data_b,
    output rf_addr_a, rf_addr_b, mem_addr_a, mem_addr_b,
    output check_done, qed_error, err_index, err_is_mem
  );
endinterface

// File: rtl/qed_consistency_checker.sv
// QED back end: once original/duplicate commit counts balance, scans r[i]/r[i+16] and
// m[i]/m[i+16] and flags the first mismatch. Memory scan enabled by QED_MEM_CHECK_EN.
module qed_consistency_checker #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  qed_consistency_checker_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRfScan, StMemScan, StDrain} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] orig_cnt_q, dup_cnt_q, last_chk_q, last_chk_d, snap_q, snap_d;
  logic             pend_q, pend_d, pend_mem_q, pend_mem_d;
  logic [3:0]       pend_idx_q;
  logic             done_q, done_d;
  logic             err_q, err_mem_q;
  logic [3:0]       err_idx_q;
  logic             trigger, abort, mismatch;

  assign trigger = bus.qed_ena && bus.pipe_empty && !bus.commit_valid &&
                   (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != last_chk_q);
  assign abort   = (state_q != StIdle) && (bus.commit_valid || !bus.qed_ena);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    last_chk_d = last_chk_q;
    done_d     = 1'b0;
    pend_d     = 1'b0;
    pend_mem_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StRfScan;
          idx_d   = 4'd1;
          snap_d  = orig_cnt_q;
        end
      end
      StRfScan: begin
        pend_d = 1'b1;
        idx_d  = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
`ifdef QED_MEM_CHECK_EN
          state_d = StMemScan;
`else
          state_d = StDrain;
`endif
          idx_d   = 4'd0;
        end
      end
      StMemScan: begin
        pend_d     = 1'b1;
        pend_mem_d = 1'b1;
        idx_d      = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = StDrain;
          idx_d   = 4'd0;
        end
      end
      StDrain: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        last_chk_d = snap_q;
      end
      default: state_d = StIdle;
    endcase
    // Abort drops the scan without completing or arming a compare.
    if (abort) begin
      state_d    = StIdle;
      idx_d      = 4'd0;
      pend_d     = 1'b0;
      pend_mem_d = 1'b0;
      done_d     = 1'b0;
      last_chk_d = last_chk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      snap_q     <= '0;
      last_chk_q <= '0;
      orig_cnt_q <= '0;
      dup_cnt_q  <= '0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_mem_q <= 1'b0;
      pend_idx_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      last_chk_q <= last_chk_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      pend_mem_q <= pend_mem_d;
      pend_idx_q <= idx_q;
      if (bus.qed_ena && bus.commit_valid) begin
        if (bus.commit_is_dup) dup_cnt_q  <= dup_cnt_q + 1'b1;
        else                   orig_cnt_q <= orig_cnt_q + 1'b1;
      end
    end
  end

`ifdef QED_MEM_CHECK_EN
  assign mismatch = pend_mem_q ? (bus.mem_data_a != bus.mem_data_b)
                               : (bus.rf_data_a != bus.rf_data_b);
`else
  assign mismatch = (bus.rf_data_a != bus.rf_data_b);
`endif

  // Only the first mismatch is recorded; later scans never overwrite it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_idx_q <= 4'd0;
      err_mem_q <= 1'b0;
    end else if (pend_q && !abort && mismatch && !err_q) begin
      err_q     <= 1'b1;
      err_idx_q <= pend_idx_q;
      err_mem_q <= pend_mem_q;
    end
  end

  assign bus.rf_addr_a  = (state_q == StRfScan) ? {1'b0, idx_q} : 5'd0;
  assign bus.rf_addr_b  = (state_q == StRfScan) ? {1'b1, idx_q} : 5'd0;
  assign bus.check_done = done_q;
  assign bus.qed_error  = err_q;
  assign bus.err_index  = err_idx_q;

`ifdef QED_MEM_CHECK_EN
  assign bus.mem_addr_a = (state_q == StMemScan) ? {1'b0, idx_q} : 5'd0;
  assign bus.mem_addr_b = (state_q == StMemScan) ? {1'b1, idx_q} : 5'd0;
  assign bus.err_is_mem = err_mem_q;
`else
  logic unused_mem;
  assign unused_mem     = ^{bus.mem_data_a, bus.mem_data_b, err_mem_q};
  assign bus.mem_addr_a = 5'd0;
  assign bus.mem_addr_b = 5'd0;
  assign bus.err_is_mem = 1'b0;
`endif

endmodule
